mac_array_ctrl: RTL and testbench
=================================

# mac_array_ctrl

Sequencer for the 3x3 signed systolic MAC array. Holds operand matrices A (3x3) and B (3x3) in local register banks. On a start request it streams them into the array with the row/column skew the array requires and pulses the per-row new-accumulation tags. After a fixed drain it captures the nine 2*DATA_W results into a readable result bank and signals completion.

## Interface
- DATA_W, 8, operand width; result width is 2*DATA_W
- DRAIN_CYC, 4, cycles waited after the last feed beat before capture (1..15)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_wr_en  in  1  write A[a_wr_addr] when idle
- b_wr_en  in  1  write B[b_wr_addr] when idle
- a_wr_addr / b_wr_addr  in  4  row-major index i*3+j, 0..8
- a_wr_data / b_wr_data  in  DATA_W  signed operand
- start  in  1  request one multiply
- busy  out  1  high from the first FEED cycle through CAPTURE
- done  out  1  one-cycle pulse; results valid
- din_r1..din_r3  out  DATA_W  row feeds to array, registered
- din_c1..din_c3  out  DATA_W  column feeds to array, registered
- in_tag_new  out  3  per-row new-accumulation tag, registered
- cell_bus  in  9*2*DATA_W  array results, Cell[i][j] at slice (i*3+j)
- res_rd_addr  in  4  result index 0..8
- res_rd_data  out  2*DATA_W  combinational read of result bank

## Operation
- States: IDLE, FEED, DRAIN, CAPTURE. Beat counter t, 3 bits. Drain counter, 4 bits.
- IDLE: start=1 -> FEED with t=0. Writes accepted only in IDLE. Writes in other states are dropped.
- FEED, beat t=0..4:
  - din_r(i+1) = A[i][t-i] when 0<=t-i<=2, else 0.
  - din_c(j+1) = B[t-j][j] when 0<=t-j<=2, else 0.
  - in_tag_new[i] = 1 only at t==i.
  - After t=4 -> DRAIN.
- DRAIN: DRAIN_CYC cycles, then CAPTURE.
- CAPTURE: one cycle. All nine cell_bus slices are registered into the result bank at the closing edge. Then -> IDLE, with done=1 in the following cycle.
- Outside FEED: din_* = 0 and in_tag_new = 0.
- start while busy: ignored, not queued. start in the done cycle (state is IDLE): accepted.
- Address >8 on write: dropped. Address >8 on read: returns 0.
- Arithmetic belongs to the array. Results are stored as delivered: 2*DATA_W two's complement, wrap on overflow.
- Reset:
  - State IDLE; busy, done, din_*, in_tag_new = 0.
  - A, B and result banks cleared to 0.
  - Reset mid-operation aborts and leaves the bank contents zeroed.

## Timing
- start sampled high at edge k. FEED beat t drives outputs during cycle k+1+t.
- DRAIN occupies cycles k+6 .. k+5+DRAIN_CYC. CAPTURE is cycle k+6+DRAIN_CYC.
- done is high in cycle k+7+DRAIN_CYC. Default start-to-done latency is 11 cycles.
- Back-to-back: start held high gives a new run every 7+DRAIN_CYC cycles.
- res_rd_data reflects the new bank from the done cycle onward.

## Configuration
- MAC_ARRAY_CTRL_PERF_EN defined:
  - Adds output perf_cnt, 16 bits, reset 0.
  - Increments every cycle busy=1.
  - Saturates at 0xFFFF.
  - Cleared by a start acceptance only when perf_clr (extra input, 1 bit) is high.
- Not defined: no perf_cnt, no perf_clr port, no counter logic.

## Structure
- Shared package mac_pkg:
  - ROW/COL/NUM = 3.
  - FEED_BEATS = ROW+NUM-1 = 5.
  - State enum.
  - Index helper constant widths.
- Sub-module mac_skew_feed:
  - Combinational beat-t to din_r/din_c/in_tag_new mapping from the A/B banks.
  - Registered in the top.

## Test plan
- A = identity, B rows {1,2,3},{4,5,6},{7,8,9}, start, with cell_bus driven by a behavioural array model -> result bank = B. done exactly 11 cycles after start.
- Skew check: A = 1..9 row-major, start.
  - din_r2 over cycles k+1..k+5 = 0,4,5,6,0.
  - in_tag_new over those cycles = 001,010,100,000,000.
- A all 1, B all 2 -> all nine results 6. A all -128, B all -128 -> all results 0xC000 (wrap of 49152).
- start pulsed again during DRAIN and A write during FEED -> no second run; A bank unchanged; single done.
- rst_n low during FEED beat 2 -> outputs 0 asynchronously; banks 0. A fresh load and start afterwards runs normally.
- With PERF_EN defined, two runs without perf_clr -> perf_cnt=20. Third start with perf_clr=1 -> perf_cnt=10 after done.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared geometry constants and state type for the MAC array sequencer
package mac_pkg;
  localparam int ROW = 3;
  localparam int COL = 3;
  localparam int NUM = 3;
  localparam int CELLS = ROW * COL;
  localparam int FEED_BEATS = ROW + NUM - 1;
  localparam int IDX_W = 4;
  localparam int BEAT_W = 3;
  localparam int DRN_W = 4;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, CAPTURE} state_e;
endpackage

// File: rtl/mac_skew_feed.sv
// mac_skew_feed: maps feed beat t to the skewed row/column operands and per-row new-accumulation tags
module mac_skew_feed
  import mac_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    en_i,
  input  logic [BEAT_W-1:0]       t_i,
  input  logic [CELLS*DATA_W-1:0] a_i,
  input  logic [CELLS*DATA_W-1:0] b_i,
  output logic [ROW*DATA_W-1:0]   din_r_o,
  output logic [COL*DATA_W-1:0]   din_c_o,
  output logic [ROW-1:0]          tag_o
);
  // row i carries A[i][k] on beat i+k, column j carries B[k][j] on beat k+j
  always_comb begin
    din_r_o = '0;
    din_c_o = '0;
    tag_o = '0;
    for (int i = 0; i < ROW; i++) begin
      tag_o[i] = en_i && int'(t_i) == i;
      for (int k = 0; k < NUM; k++)
        if (en_i && int'(t_i) == i + k) din_r_o[i*DATA_W +: DATA_W] = a_i[(i*NUM+k)*DATA_W +: DATA_W];
    end
    for (int j = 0; j < COL; j++)
      for (int k = 0; k < NUM; k++)
        if (en_i && int'(t_i) == k + j) din_c_o[j*DATA_W +: DATA_W] = b_i[(k*COL+j)*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: streams A/B banks into the 3x3 systolic MAC array and captures its results.
// Defining MAC_ARRAY_CTRL_PERF_EN adds perf_clr/perf_cnt, a saturating busy-cycle counter.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_wr_en,
  input  logic [IDX_W-1:0]          a_wr_addr,
  input  logic [DATA_W-1:0]         a_wr_data,
  input  logic                      b_wr_en,
  input  logic [IDX_W-1:0]          b_wr_addr,
  input  logic [DATA_W-1:0]         b_wr_data,
  input  logic                      start,
`ifdef MAC_ARRAY_CTRL_PERF_EN
  input  logic                      perf_clr,
  output logic [15:0]               perf_cnt,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         din_r1,
  output logic [DATA_W-1:0]         din_r2,
  output logic [DATA_W-1:0]         din_r3,
  output logic [DATA_W-1:0]         din_c1,
  output logic [DATA_W-1:0]         din_c2,
  output logic [DATA_W-1:0]         din_c3,
  output logic [ROW-1:0]            in_tag_new,
  input  logic [CELLS*2*DATA_W-1:0] cell_bus,
  input  logic [IDX_W-1:0]          res_rd_addr,
  output logic [2*DATA_W-1:0]       res_rd_data
);
  localparam int RES_W = 2 * DATA_W;
  state_e state_q, state_d;
  logic [BEAT_W-1:0] t_q, t_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [DATA_W-1:0] a_q [CELLS];
  logic [DATA_W-1:0] b_q [CELLS];
  logic [RES_W-1:0] res_q [CELLS];
  logic [CELLS*DATA_W-1:0] a_flat, b_flat;
  logic [ROW*DATA_W-1:0] feed_r, din_r_q;
  logic [COL*DATA_W-1:0] feed_c, din_c_q;
  logic [ROW-1:0] feed_tag, tag_q;
  logic done_q, idle;
  assign idle = state_q == IDLE;
  assign busy = !idle;
  for (genvar k = 0; k < CELLS; k++) begin : g_flat
    assign a_flat[k*DATA_W +: DATA_W] = a_q[k];
    assign b_flat[k*DATA_W +: DATA_W] = b_q[k];
  end
  // sequencing: IDLE -> FEED (5 beats) -> DRAIN (DRAIN_CYC) -> CAPTURE -> IDLE
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    drn_d = drn_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FEED;
        t_d = '0;
      end
      FEED: if (t_q == BEAT_W'(FEED_BEATS - 1)) begin
        state_d = DRAIN;
        drn_d = '0;
      end else t_d = t_q + 1'b1;
      DRAIN: if (drn_q == DRN_W'(DRAIN_CYC - 1)) state_d = CAPTURE;
             else drn_d = drn_q + 1'b1;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q <= '0;
      drn_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      drn_q <= drn_d;
    end
  end
  // the feed registers load the beat that will be live next cycle
  mac_skew_feed #(.DATA_W(DATA_W)) u_feed (
    .en_i   (state_d == FEED),
    .t_i    (t_d),
    .a_i    (a_flat),
    .b_i    (b_flat),
    .din_r_o(feed_r),
    .din_c_o(feed_c),
    .tag_o  (feed_tag)
  );
  // operand banks take writes only while idle; result bank samples the array at the end of CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CELLS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      if (idle && a_wr_en && a_wr_addr < IDX_W'(CELLS)) a_q[a_wr_addr] <= a_wr_data;
      if (idle && b_wr_en && b_wr_addr < IDX_W'(CELLS)) b_q[b_wr_addr] <= b_wr_data;
      if (state_q == CAPTURE)
        for (int k = 0; k < CELLS; k++) res_q[k] <= cell_bus[k*RES_W +: RES_W];
    end
  end
  // registered array feeds and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_r_q <= '0;
      din_c_q <= '0;
      tag_q <= '0;
      done_q <= 1'b0;
    end else begin
      din_r_q <= feed_r;
      din_c_q <= feed_c;
      tag_q <= feed_tag;
      done_q <= state_q == CAPTURE;
    end
  end
  assign {din_r3, din_r2, din_r1} = din_r_q;
  assign {din_c3, din_c2, din_c1} = din_c_q;
  assign in_tag_new = tag_q;
  assign done = done_q;
  assign res_rd_data = res_rd_addr < IDX_W'(CELLS) ? res_q[res_rd_addr] : '0;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;
  // busy-cycle count, saturating, optionally cleared when a run is accepted
  always_comb perf_d = (idle && start && perf_clr) ? '0 : (busy && perf_q != 16'hFFFF) ? perf_q + 1'b1 : perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_cnt = perf_q;
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: randomized self-checking bench with a cycle-level behavioural model and systolic array model
module tb_mac_array_ctrl;
  localparam int DW = 8;
  localparam int DC = 4;
  localparam int RW = 16;
  logic clk = 0, rst_n = 1, start = 0;
  logic a_wr_en = 0, b_wr_en = 0;
  logic [3:0] a_wr_addr = 0, b_wr_addr = 0, res_rd_addr = 0;
  logic [DW-1:0] a_wr_data = 0, b_wr_data = 0;
  logic busy, done;
  logic [DW-1:0] din_r1, din_r2, din_r3, din_c1, din_c2, din_c3;
  logic [2:0] in_tag_new;
  logic [9*RW-1:0] cell_bus;
  logic [RW-1:0] res_rd_data;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic perf_clr = 0;
  logic [15:0] perf_cnt;
`endif
  int n_chk = 0, n_err = 0;
  int A_t[9], B_t[9];
  int lat, rec_r2[5], rec_tg[5];
  bit hold_rd = 0;

  always #5 clk = ~clk;

  mac_array_ctrl #(.DATA_W(DW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .start(start),
`ifdef MAC_ARRAY_CTRL_PERF_EN
    .perf_clr(perf_clr), .perf_cnt(perf_cnt),
`endif
    .busy(busy), .done(done),
    .din_r1(din_r1), .din_r2(din_r2), .din_r3(din_r3),
    .din_c1(din_c1), .din_c2(din_c2), .din_c3(din_c3),
    .in_tag_new(in_tag_new), .cell_bus(cell_bus),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // systolic array: row data moves right, column data moves down, one cell per cycle
  int rp[3][3] = '{default: 0}, cp[3][3] = '{default: 0}, acc[3][3] = '{default: 0};
  initial begin : array_model
    int dr[3], dc[3], ai, bi;
    forever begin
      @(posedge clk);
      dr = '{int'($signed(din_r1)), int'($signed(din_r2)), int'($signed(din_r3))};
      dc = '{int'($signed(din_c1)), int'($signed(din_c2)), int'($signed(din_c3))};
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          ai = (j == 0) ? dr[i] : rp[i][j-1];
          bi = (i == 0) ? dc[j] : cp[i-1][j];
          rp[i][j] <= ai;
          cp[i][j] <= bi;
          acc[i][j] <= (in_tag_new[0] ? 0 : acc[i][j]) + ai * bi;
        end
    end
  end
  always_comb begin
    cell_bus = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) cell_bus[(i*3+j)*RW +: RW] = 16'(acc[i][j]);
  end

  // reference model: banks, accepted-start cycle k, expected result bank
  int mA[9], mB[9], sA[9], sB[9], eres[9];
  int cur = 0, k = -1000;
  function automatic int prod(int i, int j);
    int s = 0;
    for (int m = 0; m < 3; m++) s += sA[i*3+m] * sB[m*3+j];
    return s & 32'hFFFF;
  endfunction
  initial begin : model
    int r;
    for (int n = 0; n < 9; n++) begin mA[n] = 0; mB[n] = 0; sA[n] = 0; sB[n] = 0; eres[n] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int n = 0; n < 9; n++) begin mA[n] = 0; mB[n] = 0; sA[n] = 0; sB[n] = 0; eres[n] = 0; end
        k = -1000;
      end else begin
        r = cur - k;
        if (!(r >= 1 && r <= 6 + DC)) begin
          if (a_wr_en && a_wr_addr < 9) mA[a_wr_addr] = int'($signed(a_wr_data));
          if (b_wr_en && b_wr_addr < 9) mB[b_wr_addr] = int'($signed(b_wr_data));
          if (start) begin k = cur; sA = mA; sB = mB; end
        end
        if (r == 6 + DC)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) eres[i*3+j] = prod(i, j);
      end
      if (clk) cur++;
    end
  end

  // every-cycle comparison of all outputs against the model
  initial begin : cmp
    int r, t, dr[3], dc[3], er, ec;
    bit fd;
    forever begin
      @(posedge clk);
      #1;
      r = cur - k;
      t = r - 1;
      fd = r >= 1 && r <= 5;
      chk("busy", int'(busy), int'(r >= 1 && r <= 6 + DC));
      chk("done", int'(done), int'(r == 7 + DC));
      dr = '{int'($signed(din_r1)), int'($signed(din_r2)), int'($signed(din_r3))};
      dc = '{int'($signed(din_c1)), int'($signed(din_c2)), int'($signed(din_c3))};
      for (int i = 0; i < 3; i++) begin
        er = (fd && t - i >= 0 && t - i <= 2) ? sA[i*3+t-i] : 0;
        ec = (fd && t - i >= 0 && t - i <= 2) ? sB[(t-i)*3+i] : 0;
        chk($sformatf("din_r%0d", i + 1), dr[i], er);
        chk($sformatf("din_c%0d", i + 1), dc[i], ec);
      end
      chk("in_tag_new", int'(in_tag_new), (fd && t < 3) ? (1 << t) : 0);
      chk("res_rd_data", int'(res_rd_data), res_rd_addr < 9 ? eres[res_rd_addr] : 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!hold_rd) res_rd_addr = 4'($urandom_range(0, 15));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input bit isb, input int addr, input int data);
    @(negedge clk);
    if (isb) begin b_wr_en = 1; b_wr_addr = 4'(addr); b_wr_data = 8'(data); end
    else begin a_wr_en = 1; a_wr_addr = 4'(addr); a_wr_data = 8'(data); end
    @(negedge clk);
    a_wr_en = 0;
    b_wr_en = 0;
  endtask

  task automatic load();
    for (int n = 0; n < 9; n++) begin
      wr(0, n, A_t[n]);
      wr(1, n, B_t[n]);
    end
  endtask

  task automatic rd(input int addr, input int exp, input string nm);
    hold_rd = 1;
    @(negedge clk);
    res_rd_addr = 4'(addr);
    #1 chk(nm, int'(res_rd_data), exp);
    hold_rd = 0;
  endtask

  task automatic run(input bit noisy);
    @(negedge clk);
    start = 1;
    for (lat = 1; lat <= 60; lat++) begin
      @(negedge clk);
      start = 0;
      a_wr_en = 0;
      b_wr_en = 0;
      if (lat <= 5) begin
        rec_r2[lat-1] = int'($signed(din_r2));
        rec_tg[lat-1] = int'(in_tag_new);
      end
      if (done) break;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        a_wr_en = 1'($urandom_range(0, 1));
        a_wr_addr = 4'($urandom_range(0, 15));
        a_wr_data = 8'($urandom);
        b_wr_en = 1'($urandom_range(0, 1));
        b_wr_addr = 4'($urandom_range(0, 15));
        b_wr_data = 8'($urandom);
      end
    end
    if (!done) chk("done_timeout", int'(done), 1);
  endtask

  initial begin
    int exp_r2[5] = '{0, 4, 5, 6, 0};
    int exp_tg[5] = '{1, 2, 4, 0, 0};
    int nd, gap;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_din_r1", int'(din_r1), 0);
    chk("rst_tag", int'(in_tag_new), 0);
    rd(0, 0, "rst_res0");

    // identity A, B = 1..9: result bank must equal B, latency 11
    for (int n = 0; n < 9; n++) begin A_t[n] = (n % 4 == 0) ? 1 : 0; B_t[n] = n + 1; end
    load();
    run(0);
    chk("latency", lat, 11);
    for (int n = 0; n < 9; n++) rd(n, n + 1, $sformatf("ident_res%0d", n));
    rd(12, 0, "res_oob");

    // skew pattern on row 2 and tags
    for (int n = 0; n < 9; n++) A_t[n] = n + 1;
    load();
    run(0);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("skew_r2_%0d", n), rec_r2[n], exp_r2[n]);
      chk($sformatf("skew_tag_%0d", n), rec_tg[n], exp_tg[n]);
    end

    // constant matrices and overflow wrap
    for (int n = 0; n < 9; n++) begin A_t[n] = 1; B_t[n] = 2; end
    load();
    run(0);
    for (int n = 0; n < 9; n++) rd(n, 6, $sformatf("ones_res%0d", n));
    for (int n = 0; n < 9; n++) begin A_t[n] = -128; B_t[n] = -128; end
    load();
    run(0);
    for (int n = 0; n < 9; n++) rd(n, 49152, $sformatf("wrap_res%0d", n));

    // write during FEED and start during DRAIN are ignored
    for (int n = 0; n < 9; n++) begin A_t[n] = n + 1; B_t[n] = (n % 4 == 0) ? 1 : 0; end
    load();
    wr(0, 13, 55);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); a_wr_en = 1; a_wr_addr = 0; a_wr_data = 77;
    @(negedge clk); a_wr_en = 0;
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk); start = 0;
    nd = 0;
    repeat (20) begin @(negedge clk); nd += int'(done); end
    chk("single_done", nd, 1);
    rd(0, 1, "keepA_res0");
    rd(4, 5, "keepA_res4");

    // start held high: runs every 7+DRAIN_CYC cycles
    @(negedge clk); start = 1;
    nd = 0;
    while (!done && nd < 40) begin @(negedge clk); nd++; end
    gap = 0;
    do begin @(negedge clk); gap++; end while (!done && gap < 40);
    start = 0;
    chk("b2b_gap", gap, 11);
    nd = 0;
    while ((busy || done) && nd < 40) begin @(negedge clk); nd++; end

    // randomized runs with writes/starts thrown at the busy sequencer
    repeat (8) begin
      for (int n = 0; n < 9; n++) begin
        A_t[n] = $urandom_range(0, 255) - 128;
        B_t[n] = $urandom_range(0, 255) - 128;
      end
      load();
      wr($urandom_range(0, 1), $urandom_range(9, 15), $urandom_range(0, 255));
      run(1);
      chk("rand_latency", lat, 11);
      hold_rd = 1;
      for (int n = 0; n < 16; n++) begin @(negedge clk); res_rd_addr = 4'(n); end
      hold_rd = 0;
    end

    // reset during FEED beat 2
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_dins", int'({din_r1, din_r2, din_r3, din_c1, din_c2, din_c3}), 0);
    chk("arst_tag", int'(in_tag_new), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 9; n++) rd(n, 0, $sformatf("arst_res%0d", n));
    for (int n = 0; n < 9; n++) wr(1, n, (n % 4 == 0) ? 1 : 0);
    run(0);
    rd(4, 0, "arst_A_cleared");
    for (int n = 0; n < 9; n++) begin A_t[n] = 9 - n; B_t[n] = (n % 4 == 0) ? 1 : 0; end
    load();
    run(0);
    chk("post_rst_latency", lat, 11);
    rd(2, 7, "post_rst_res2");

`ifdef MAC_ARRAY_CTRL_PERF_EN
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    run(0);
    run(0);
    chk("perf_two_runs", int'(perf_cnt), 20);
    perf_clr = 1;
    run(0);
    perf_clr = 0;
    chk("perf_cleared", int'(perf_cnt), 10);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
